// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: word size, PC step, fetch FSM encoding.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1
  } fetch_state_t;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory req/ack port; master = fetch stage, slave = memory.
interface inst_fetch_if;

  logic                       IMemReq;
  logic [cpu_pkg::WORD_W-1:0] IMemAddr;
  logic                       IMemAck;
  logic [cpu_pkg::WORD_W-1:0] IMemData;

  modport master (output IMemReq, IMemAddr, input IMemAck, IMemData);
  modport slave  (input IMemReq, IMemAddr, output IMemAck, IMemData);

endinterface

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO with push/pop/clear and occupancy outputs.
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64,
  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, req/ack memory port, prefetch queue, branch flush.
// Optional INST_FETCH_PERFCNT_EN enables the delivered-instruction counter.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned       DEPTH     = 2
) (
  input  logic              CLK,
  input  logic              RST,
  inst_fetch_if.master      imem,
  input  logic              Stall,
  input  logic              BranchEn,
  input  logic [WORD_W-1:0] BranchAddr,
  output logic [WORD_W-1:0] OPCODE,
  output logic              OpValid,
  output logic [WORD_W-1:0] PCOut,
  output logic [WORD_W-1:0] FetchCnt
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_state_t      state_q, state_n;
  logic              req_q, req_n;
  logic [WORD_W-1:0] addr_q, addr_n;
  logic [WORD_W-1:0] tgt_q, tgt_n;
  logic [WORD_W-1:0] hold_op, hold_pc;
  logic [WORD_W-1:0] br_tgt;
  logic              ack_ok, push, pop, clear, room_next;
  logic              q_full, q_empty;
  logic [CW-1:0]     q_count;
  logic [2*WORD_W-1:0] q_rd;

  assign br_tgt = word_align(BranchAddr);
  assign ack_ok = req_q && imem.IMemAck;
  assign clear  = BranchEn;
  assign pop    = !q_empty && !Stall;
  assign push   = ack_ok && (state_q == RUN) && !BranchEn;

  // Occupancy after this edge is below DEPTH, derived from current count/full.
  always_comb begin
    room_next = 1'b1;
    if (clear)              room_next = 1'b1;
    else if (push && !pop)  room_next = (q_count < CW'(DEPTH - 1));
    else                    room_next = !q_full || (pop && !push);
  end

  fetch_queue #(.DEPTH(DEPTH), .W(2 * WORD_W)) u_queue (
    .clk     (CLK),
    .rst     (RST),
    .push    (push),
    .pop     (pop),
    .clear   (clear),
    .wr_data ({addr_q, imem.IMemData}),
    .rd_data (q_rd),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  always_comb begin
    state_n = state_q;
    req_n   = req_q;
    addr_n  = addr_q;
    tgt_n   = tgt_q;
    case (state_q)
      RUN: begin
        if (BranchEn) begin
          if (req_q && !imem.IMemAck) begin
            state_n = FLUSH;
            tgt_n   = br_tgt;
          end else begin
            req_n  = 1'b1;
            addr_n = br_tgt;
          end
        end else begin
          if (ack_ok) addr_n = addr_q + PC_INC;
          req_n = (req_q && !ack_ok) || room_next;
        end
      end
      FLUSH: begin
        if (BranchEn) tgt_n = br_tgt;
        if (ack_ok) begin
          state_n = RUN;
          req_n   = 1'b1;
          addr_n  = BranchEn ? br_tgt : tgt_q;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      req_q   <= 1'b0;
      addr_q  <= RESET_VEC;
      tgt_q   <= RESET_VEC;
      hold_op <= '0;
      hold_pc <= '0;
    end else begin
      state_q <= state_n;
      req_q   <= req_n;
      addr_q  <= addr_n;
      tgt_q   <= tgt_n;
      if (!q_empty) begin
        hold_op <= q_rd[WORD_W-1:0];
        hold_pc <= q_rd[2*WORD_W-1:WORD_W];
      end
    end
  end

  assign imem.IMemReq  = req_q;
  assign imem.IMemAddr = addr_q;
  assign OpValid = !q_empty;
  assign OPCODE  = q_empty ? hold_op : q_rd[WORD_W-1:0];
  assign PCOut   = q_empty ? hold_pc : q_rd[2*WORD_W-1:WORD_W];

`ifdef INST_FETCH_PERFCNT_EN
  logic [WORD_W-1:0] cnt_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + 32'd1;
  end
  assign FetchCnt = cnt_q;
`else
  assign FetchCnt = '0;
`endif

endmodule
